// File: rtl/ewb_controller.sv
// rtl/ewb_controller.sv - L2 eviction write buffer sequencing and memory-port arbitration
module ewb_controller #(
  parameter int DRAIN_DELAY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         c_read,
  input  logic         c_write,
  input  logic [31:0]  c_address,
  output logic [255:0] c_rdata,
  output logic         c_resp,
  output logic         ewb_load,
  output logic         ewb_empty,
  output logic [31:0]  ewb_hit_addr,
  input  logic         ewb_full,
  input  logic         ewb_hit,
  input  logic [255:0] ewb_wdata,
  input  logic [31:0]  ewb_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int CNT_W = (DRAIN_DELAY < 1) ? 1 : $clog2(DRAIN_DELAY + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MEM  = 2'd1,
    WRITE_MEM = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               pend_write_q, pend_write_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [255:0]       c_rdata_q, c_rdata_d;

  assign c_rdata      = c_rdata_q;
  assign ewb_hit_addr = c_address;
  assign pmem_wdata   = ewb_wdata;

  // State, drain counter, pending-write flag and returned line
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pend_write_q <= 1'b0;
      idle_cnt_q   <= '0;
      c_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_write_q <= pend_write_d;
      idle_cnt_q   <= idle_cnt_d;
      c_rdata_q    <= c_rdata_d;
    end
  end

  // Next-state and output decode; reset forces outputs quiet and clears the EWB
  always_comb begin
    state_d      = state_q;
    pend_write_d = pend_write_q;
    idle_cnt_d   = '0;
    c_rdata_d    = c_rdata_q;
    c_resp       = 1'b0;
    ewb_load     = 1'b0;
    ewb_empty    = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;

    unique case (state_q)
      IDLE: begin
        if (c_write) begin
          if (!ewb_full) begin
            ewb_load = 1'b1;
            state_d  = RESP;
          end else begin
            pend_write_d = 1'b1;
            state_d      = WRITE_MEM;
          end
        end else if (c_read) begin
          if (ewb_full && ewb_hit) begin
            c_rdata_d = ewb_wdata;
            state_d   = RESP;
          end else begin
            state_d = READ_MEM;
          end
        end else if (ewb_full) begin
          if (idle_cnt_q == CNT_W'(DRAIN_DELAY)) begin
            state_d = WRITE_MEM;
          end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
        end
      end
      READ_MEM: begin
        pmem_read    = 1'b1;
        pmem_address = c_address;
        if (pmem_resp) begin
          c_rdata_d = pmem_rdata;
          state_d   = RESP;
        end
      end
      WRITE_MEM: begin
        pmem_write   = 1'b1;
        pmem_address = ewb_address;
        if (pmem_resp) begin
          // The held c_write reloads the emptied EWB from IDLE next cycle
          ewb_empty    = 1'b1;
          pend_write_d = 1'b0;
          state_d      = IDLE;
        end
      end
      RESP: begin
        c_resp  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!rst) begin
      c_resp       = 1'b0;
      ewb_load     = 1'b0;
      ewb_empty    = 1'b1;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
    end
  end

endmodule

// File: tb/tb_ewb_controller.sv
// tb/tb_ewb_controller.sv - self-checking bench for ewb_controller
module tb_ewb_controller;

  localparam int DD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         c_read = 1'b0, c_write = 1'b0;
  logic [31:0]  c_address = '0;
  logic [255:0] c_rdata;
  logic         c_resp, ewb_load, ewb_empty;
  logic [31:0]  ewb_hit_addr;
  logic         ewb_full = 1'b0;
  logic         ewb_hit;
  logic [255:0] ewb_wdata = '0;
  logic [31:0]  ewb_address = '0;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  always #5 clk = ~clk;

  ewb_controller #(.DRAIN_DELAY(DD)) dut (
    .clk(clk), .rst(rst), .c_read(c_read), .c_write(c_write), .c_address(c_address),
    .c_rdata(c_rdata), .c_resp(c_resp), .ewb_load(ewb_load), .ewb_empty(ewb_empty),
    .ewb_hit_addr(ewb_hit_addr), .ewb_full(ewb_full), .ewb_hit(ewb_hit),
    .ewb_wdata(ewb_wdata), .ewb_address(ewb_address), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  function automatic logic [255:0] mem_pat(input logic [31:0] a);
    return {4{a, ~a}};
  endfunction

  function automatic logic [255:0] ewb_pat(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_5A5A}};
  endfunction

  // Behavioural EWB: preload backdoor, capture on load, clear on empty
  logic         pre_req = 1'b0;
  logic [31:0]  pre_addr = '0, evict_addr = '0;
  always @(posedge clk) begin
    if (ewb_empty) ewb_full <= 1'b0;
    else if (ewb_load) begin
      ewb_full <= 1'b1; ewb_address <= evict_addr; ewb_wdata <= ewb_pat(evict_addr);
    end else if (pre_req) begin
      ewb_full <= 1'b1; ewb_address <= pre_addr; ewb_wdata <= ewb_pat(pre_addr);
    end
  end
  assign ewb_hit = ewb_full && (ewb_address == ewb_hit_addr);

  // Memory model: request held mem_lat cycles, resp in the last of them
  int mem_lat = 5;
  int mem_cnt = 0;
  always @(posedge clk) begin
    pmem_resp <= 1'b0;
    if ((pmem_read || pmem_write) && !pmem_resp) begin
      if (mem_cnt >= mem_lat - 2) begin
        pmem_resp <= 1'b1; pmem_rdata <= mem_pat(pmem_address); mem_cnt <= 0;
      end else mem_cnt <= mem_cnt + 1;
    end else mem_cnt <= 0;
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic        pre_full;
    logic [31:0] pre_addr;
    int          lat;
    int          exp_resp;
    int          exp_rd;
    int          exp_wr;
    int          exp_ld;
  } vec_t;

  typedef struct {
    logic         is_rd;
    logic [255:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int checks = 0, errors = 0;
  int rd_n, wr_n, ld_n, em_n;

  task automatic chk(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic mon();
    chk(!(ewb_load && ewb_empty), "load_empty_excl", 256'(ewb_load && ewb_empty), 0);
    chk(!(pmem_read && pmem_write), "rd_wr_excl", 256'(pmem_read && pmem_write), 0);
    chk(ewb_hit_addr == c_address, "hit_addr", ewb_hit_addr, c_address);
    if (pmem_read) chk(pmem_address == c_address, "rd_addr", pmem_address, c_address);
    if (pmem_write) begin
      chk(pmem_address == ewb_address, "wr_addr", pmem_address, ewb_address);
      chk(pmem_wdata == ewb_wdata, "wr_data", pmem_wdata, ewb_wdata);
    end
  endtask

  // which: 0 waits for c_resp, 1 waits for pmem_write; idx is the cycle it was seen
  task automatic wait_ev(input int which, output int idx);
    idx = -1; rd_n = 0; wr_n = 0; ld_n = 0; em_n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      mon();
      rd_n += int'(pmem_read); wr_n += int'(pmem_write);
      ld_n += int'(ewb_load);  em_n += int'(ewb_empty);
      if ((which == 0 && c_resp) || (which == 1 && pmem_write)) begin
        idx = i;
        break;
      end
    end
    if (idx < 0) chk(1'b0, "timeout", 256'(which), 256'(1));
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0; c_read = 1'b0; c_write = 1'b0; pre_req = 1'b0;
    @(negedge clk);
    chk(ewb_empty == 1'b1, "rst_ewb_empty", 256'(ewb_empty), 1);
    chk(!(c_resp || ewb_load || pmem_read || pmem_write), "rst_ctrl_quiet",
        256'({c_resp, ewb_load, pmem_read, pmem_write}), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic preload(input logic [31:0] a);
    @(posedge clk); #1;
    pre_addr = a; pre_req = 1'b1;
    @(posedge clk); #1;
    pre_req = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int idx;
    exp_t e;
    mem_lat = v.lat;
    apply_reset();
    if (v.pre_full) preload(v.pre_addr);
    else begin @(posedge clk); #1; end
    c_address  = v.addr;
    evict_addr = v.addr ^ 32'h1000_0000;
    c_write    = v.wr;
    c_read     = !v.wr;
    sb.push_back('{is_rd: !v.wr,
                   data: (v.pre_full && v.pre_addr == v.addr) ? ewb_pat(v.addr) : mem_pat(v.addr)});
    wait_ev(0, idx);
    e = sb.pop_front();
    if (idx >= 0) begin
      if (e.is_rd) chk(c_rdata == e.data, $sformatf("v%0d_rdata", n), c_rdata, e.data);
      chk(idx == v.exp_resp, $sformatf("v%0d_resp_cyc", n), 256'(idx), 256'(v.exp_resp));
      chk(rd_n == v.exp_rd, $sformatf("v%0d_rd_cycles", n), 256'(rd_n), 256'(v.exp_rd));
      chk(wr_n == v.exp_wr, $sformatf("v%0d_wr_cycles", n), 256'(wr_n), 256'(v.exp_wr));
      chk(ld_n == v.exp_ld, $sformatf("v%0d_loads", n), 256'(ld_n), 256'(v.exp_ld));
    end
    @(posedge clk); #1;
    c_read = 1'b0; c_write = 1'b0;
  endtask

  initial begin
    int idx;
    exp_t e;
    //          wr    addr          pre   pre_addr      lat resp rd wr ld
    vecs[0] = '{1'b0, 32'h0000_1A40, 1'b1, 32'h0000_1A40, 5, 1,   0, 0, 0};
    vecs[1] = '{1'b0, 32'h0000_2000, 1'b0, 32'h0000_0000, 5, 6,   5, 0, 0};
    vecs[2] = '{1'b0, 32'h0000_3000, 1'b1, 32'h0000_1A40, 3, 4,   3, 0, 0};
    vecs[3] = '{1'b1, 32'h0000_4000, 1'b0, 32'h0000_0000, 5, 1,   0, 0, 1};
    vecs[4] = '{1'b1, 32'h0000_4040, 1'b1, 32'h8000_0020, 4, 6,   0, 4, 1};
    vecs[5] = '{1'b0, 32'h0000_5000, 1'b0, 32'h0000_0000, 2, 3,   2, 0, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(ewb_empty == 1'b1, "init_ewb_empty", 256'(ewb_empty), 1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk(c_rdata == '0, "init_rdata", c_rdata, 0);
    chk(pmem_address == '0, "init_paddr", pmem_address, 0);
    chk(!(c_resp || pmem_read || pmem_write), "init_ctrl", 256'({c_resp, pmem_read, pmem_write}), 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Reset in the middle of a memory read abandons it
    apply_reset();
    mem_lat = 20;
    @(posedge clk); #1;
    c_address = 32'h0000_6000; c_read = 1'b1;
    repeat (3) @(negedge clk);
    chk(pmem_read == 1'b1, "mid_rd_active", 256'(pmem_read), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk(ewb_empty == 1'b1, "mid_rst_empty", 256'(ewb_empty), 1);
    chk(pmem_read == 1'b0 && c_resp == 1'b0, "mid_rst_quiet", 256'({pmem_read, c_resp}), 0);
    @(posedge clk); #1;
    rst = 1'b1; c_read = 1'b0;
    rd_n = 0; idx = 0;
    repeat (25) begin
      @(negedge clk);
      rd_n += int'(pmem_read); idx += int'(c_resp);
    end
    chk(rd_n == 0 && idx == 0, "after_rst_idle", 256'({rd_n[15:0], idx[15:0]}), 0);
    chk(c_rdata == '0, "after_rst_rdata", c_rdata, 0);

    // Opportunistic drain after DD idle cycles with EWB full
    apply_reset();
    mem_lat = 3;
    preload(32'h9000_0040);
    wait_ev(1, idx);
    chk(idx == DD + 1, "drain_start", 256'(idx), 256'(DD + 1));
    em_n = 0;
    repeat (5) begin @(negedge clk); mon(); em_n += int'(ewb_empty); end
    chk(em_n == 1, "drain_empty_pulses", 256'(em_n), 1);
    chk(ewb_full == 1'b0, "drain_ewb_cleared", 256'(ewb_full), 0);

    // A read at idle cycle 3 takes priority; the drain counter restarts after it
    apply_reset();
    mem_lat = 3;
    preload(32'h9000_0080);
    wr_n = 0;
    repeat (3) begin @(negedge clk); wr_n += int'(pmem_write); @(posedge clk); #1; end
    c_address = 32'h0000_A000; c_read = 1'b1;
    sb.push_back('{is_rd: 1'b1, data: mem_pat(32'h0000_A000)});
    idx = wr_n;
    wait_ev(0, idx);
    e = sb.pop_front();
    chk(c_rdata == e.data, "prio_rdata", c_rdata, e.data);
    chk(idx == 4, "prio_resp_cyc", 256'(idx), 4);
    chk(wr_n == 0, "prio_no_write", 256'(wr_n), 0);
    @(posedge clk); #1;
    c_read = 1'b0;
    wait_ev(1, idx);
    chk(idx == DD + 1, "prio_drain_restart", 256'(idx), 256'(DD + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ewb_controller.md
# ewb_controller

Sequencing and arbitration controller for the L2 eviction write buffer (EWB). It sits between the L2 cache control logic, the EWB and the single physical-memory port. It absorbs dirty-line evictions into the EWB and serves miss reads, either from the EWB on a hit or from memory. It drains the EWB to memory opportunistically when the memory port has been idle, and gives reads priority over writeback.

## Interface
- DRAIN_DELAY, default 4: consecutive idle cycles with EWB full before an opportunistic drain starts; 0 means drain on the first idle cycle.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low.
- c_read  in  1  cache miss read request; held until c_resp.
- c_write  in  1  cache eviction request (line already presented to EWB data/address inputs); held until c_resp.
- c_address  in  32  line address of the current c_read.
- c_rdata  out  256  read line returned to cache; registered; valid when c_resp=1.
- c_resp  out  1  one-cycle completion pulse for c_read or c_write.
- ewb_load  out  1  capture strobe to the EWB.
- ewb_empty  out  1  clear strobe to the EWB.
- ewb_hit_addr  out  32  address compared by the EWB; equals c_address.
- ewb_full  in  1  EWB holds a line not yet written back.
- ewb_hit  in  1  EWB holds c_address (valid only while full).
- ewb_wdata  in  256  line held in the EWB.
- ewb_address  in  32  address held in the EWB.
- pmem_read  out  1  memory read request.
- pmem_write  out  1  memory write request.
- pmem_address  out  32  memory address.
- pmem_wdata  out  256  memory write data; equals ewb_wdata.
- pmem_rdata  in  256  memory read data; valid with pmem_resp.
- pmem_resp  in  1  memory completion pulse.

## Operation
- States: IDLE, READ_MEM, WRITE_MEM, RESP. An internal pend_write flag marks a write that is waiting for the EWB to drain. An idle counter idle_cnt is sized to hold DRAIN_DELAY.
- IDLE priority order, highest first: c_write, c_read, opportunistic drain.
- IDLE, c_write=1, ewb_full=0:
  - ewb_load=1 this cycle; go to RESP.
- IDLE, c_write=1, ewb_full=1:
  - set pend_write; go to WRITE_MEM (forced drain).
- IDLE, c_read=1, c_write=0, ewb_hit=1:
  - c_rdata <= ewb_wdata; go to RESP; no memory access.
- IDLE, c_read=1, c_write=0, ewb_hit=0:
  - go to READ_MEM.
- IDLE, no request, ewb_full=1:
  - idle_cnt increments each cycle.
  - When idle_cnt==DRAIN_DELAY, go to WRITE_MEM.
  - idle_cnt clears on any request, when ewb_full=0, and on leaving IDLE.
- READ_MEM:
  - pmem_read=1, pmem_address=c_address.
  - On pmem_resp: c_rdata <= pmem_rdata; go to RESP.
- WRITE_MEM:
  - pmem_write=1, pmem_address=ewb_address.
  - On pmem_resp: ewb_empty=1 this cycle.
  - If pend_write: ewb_load=1 in the same cycle is forbidden, so return to IDLE; the still-held c_write then loads the now-empty EWB. Clear pend_write.
  - Otherwise return to IDLE.
  - A c_read arriving during WRITE_MEM waits; the write is never aborted.
- RESP: c_resp=1; all requests ignored; go to IDLE unconditionally.
- ewb_load and ewb_empty are never both 1. pmem_read and pmem_write are never both 1.
- While rst=0, ewb_empty=1 combinationally so the EWB clears.

## Timing
- Reset, applied at any time including mid-transaction:
  - Next edge: state=IDLE, pend_write=0, idle_cnt=0, c_rdata=0.
  - c_resp, ewb_load, pmem_read, pmem_write = 0; pmem_address = 0.
  - An outstanding memory transaction is abandoned.
- All control outputs are Moore/Mealy decodes of state plus inputs. Only c_rdata, state, idle_cnt and pend_write are registered.
- c_resp rises exactly one cycle after the deciding edge:
  - EWB load: request seen in IDLE at cycle N, c_resp at N+1.
  - EWB hit read: c_resp at N+1, c_rdata valid at N+1.
  - Memory read: c_resp one cycle after the pmem_resp cycle.
- Write with full EWB: drain latency + 1 IDLE cycle + 1 RESP cycle.
- Opportunistic drain: pmem_write rises DRAIN_DELAY+1 cycles after EWB became full with no requests.
- pmem_resp outside READ_MEM/WRITE_MEM is ignored.

## Test plan
- Reset: drive rst=0 during READ_MEM → next cycle state IDLE, pmem_read=0, c_resp=0, ewb_empty=1 while low.
- Eviction into empty EWB: c_write=1, ewb_full=0 → ewb_load=1 in cycle 0, c_resp=1 in cycle 1, no pmem activity.
- Read hit in EWB: ewb_full=1, ewb_address=c_address=0x0000_1A40, ewb_wdata=pattern A → c_resp next cycle with c_rdata=A, pmem_read never asserted.
- Read miss: c_read, ewb_hit=0, pmem_resp after 5 cycles with pattern B → pmem_read high 5 cycles, pmem_address=c_address, c_resp one cycle later with c_rdata=B.
- Eviction with full EWB: c_write, ewb_full=1, ewb_address=0x8000_0020 → pmem_write to 0x8000_0020. On pmem_resp: ewb_empty=1. Then ewb_load in the following IDLE cycle, c_resp the next cycle.
- Opportunistic drain, DRAIN_DELAY=4: EWB full, idle → pmem_write rises on the 5th idle cycle. Repeat with c_read at idle cycle 3 → read served first, counter restarts.
